// File: rtl/rx_slot_pkg.sv
// Shared types for the rx slot manager: slot/FSM state encodings and the rx descriptor layout.
// Descriptor field widths follow the default SLOT_W/LEN_W of rx_slot_manager.
package rx_slot_pkg;

  localparam int RX_SLOT_W   = 2;
  localparam int RX_LEN_W    = 11;
  localparam int ERR_W       = 6;
  localparam int LEN_OVF_BIT = 5;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2,
    OWNED   = 2'd3
  } slot_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } wr_fsm_e;

  typedef struct packed {
    logic [RX_SLOT_W-1:0] slot;
    logic [RX_LEN_W-1:0]  len;
    logic [ERR_W-1:0]     err;
  } rx_desc_t;

endpackage

// File: rtl/rx_desc_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO of rx descriptors with full/empty/count.
// Latency: a pushed entry is visible on out_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; push and pop may coincide.
module rx_desc_fifo
  import rx_slot_pkg::*;
#(
  parameter int DEPTH_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  rx_desc_t         in_dat,
  input  logic             out_rdy,
  output rx_desc_t         out_dat,
  output logic             full,
  output logic             empty,
  output logic [DEPTH_W:0] count
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);

  rx_desc_t             mem [DEPTH];
  logic [DEPTH_W-1:0]   wr_ptr;
  logic [DEPTH_W-1:0]   rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == DEPTH_L);
  assign empty   = (count == '0);
  assign do_push = in_vld && !full;
  assign do_pop  = out_rdy && !empty;
  assign out_dat = mem[rd_ptr];

  // Storage carries no reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_W+1)'(1);
        2'b01:   count <= count - (DEPTH_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_slot_manager.sv
// Purpose: ring-allocates packet RAM slots to the rx writer, queues descriptors, tracks ownership until release.
// Latency: wr_grant 1 cycle after wr_req when the ring slot is FREE; descriptor visible the cycle after wr_done.
// Backpressure: a busy ring slot stalls grants; descriptors wait until desc_ready. RX_SLOT_DROP_ERR_EN drops errored frames.
module rx_slot_manager
  import rx_slot_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int SLOT_W   = RX_SLOT_W,
  parameter int LEN_W    = RX_LEN_W,
  parameter int AFULL_TH = 1
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic              wr_req,
  output logic              wr_grant,
  output logic [ADDR_W-1:0] wr_base,
  input  logic              wr_done,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [4:0]        wr_err,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [SLOT_W-1:0] desc_slot,
  output logic [LEN_W-1:0]  desc_len,
  output logic [ERR_W-1:0]  desc_err,
  input  logic              rel_valid,
  input  logic [SLOT_W-1:0] rel_slot,
  output logic              rel_err,
  output logic [SLOT_W:0]   free_count,
  output logic              rx_afull
`ifdef RX_SLOT_DROP_ERR_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int NUM_SLOTS  = 1 << SLOT_W;
  localparam int SLOT_WORDS = 1 << (ADDR_W - SLOT_W);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(SLOT_WORDS * 4);
  localparam logic [SLOT_W:0]  ALL_FREE  = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W:0]  AFULL_LIM = (SLOT_W+1)'(AFULL_TH);

  slot_state_e       st_q [NUM_SLOTS];
  slot_state_e       st_d [NUM_SLOTS];
  wr_fsm_e           fsm_q;
  logic [SLOT_W-1:0] alloc_ptr;
  logic [SLOT_W:0]   free_d;

  logic              grant_go;
  logic              done_go;
  logic              drop_go;
  logic              push_go;
  logic              pop_go;
  logic              rel_ok;
  logic              rel_bad;
  logic              len_ovf;

  rx_desc_t          push_dat;
  rx_desc_t          head_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SLOT_W:0]   fifo_cnt;

  assign len_ovf  = (wr_len > MAX_LEN);
  // Strict ring order: only the slot under alloc_ptr is ever considered.
  assign grant_go = (fsm_q == IDLE) && wr_req && (st_q[alloc_ptr] == FREE);
  assign done_go  = (fsm_q == FILL) && wr_done;

`ifdef RX_SLOT_DROP_ERR_EN
  assign drop_go  = done_go && (len_ovf || (wr_err != 5'd0));
`else
  assign drop_go  = 1'b0;
`endif

  assign push_go  = done_go && !drop_go && !fifo_full;
  assign pop_go   = desc_ready && !fifo_empty;
  assign rel_ok   = rel_valid && (st_q[rel_slot] == OWNED);
  assign rel_bad  = rel_valid && (st_q[rel_slot] != OWNED);

  always_comb begin
    push_dat      = '0;
    push_dat.slot = alloc_ptr;
    push_dat.len  = len_ovf ? MAX_LEN : wr_len;
    push_dat.err  = {len_ovf, wr_err};
  end

  // Each event targets a slot in a distinct state, so the updates never collide.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_d[i] = st_q[i];
    end
    if (grant_go) begin
      st_d[alloc_ptr] = FILLING;
    end
    if (done_go) begin
      st_d[alloc_ptr] = drop_go ? FREE : READY;
    end
    if (pop_go) begin
      st_d[head_dat.slot] = OWNED;
    end
    if (rel_ok) begin
      st_d[rel_slot] = FREE;
    end
    free_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st_d[i] == FREE) begin
        free_d = free_d + (SLOT_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_original) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= FREE;
      end
      fsm_q      <= IDLE;
      alloc_ptr  <= '0;
      wr_grant   <= 1'b0;
      wr_base    <= '0;
      rel_err    <= 1'b0;
      free_count <= ALL_FREE;
      rx_afull   <= (ALL_FREE <= AFULL_LIM);
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= st_d[i];
      end
      wr_grant   <= grant_go;
      rel_err    <= rel_bad;
      free_count <= free_d;
      rx_afull   <= (free_d <= AFULL_LIM);
      if (grant_go) begin
        fsm_q   <= FILL;
        wr_base <= {alloc_ptr, {(ADDR_W-SLOT_W){1'b0}}};
      end else if (done_go) begin
        fsm_q     <= IDLE;
        alloc_ptr <= alloc_ptr + SLOT_W'(1);
      end
    end
  end

`ifdef RX_SLOT_DROP_ERR_EN
  always_ff @(posedge clk_original) begin
    if (rst) begin
      drop_cnt <= 16'd0;
    end else if (drop_go && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  rx_desc_fifo #(
    .DEPTH_W (SLOT_W)
  ) u_desc_fifo (
    .clk     (clk_original),
    .rst     (rst),
    .in_vld  (push_go),
    .in_dat  (push_dat),
    .out_rdy (pop_go),
    .out_dat (head_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign desc_valid = (fifo_cnt != '0);
  assign desc_slot  = head_dat.slot;
  assign desc_len   = head_dat.len;
  assign desc_err   = head_dat.err;

endmodule
